// File: rtl/fpu_pkg.sv
// Shared FPU definitions: word layout, result status codes and scheduler state.
// Used by both the scheduler and the FPU datapath.
package fpu_pkg;

    localparam int unsigned EXP_W  = 10;
    localparam int unsigned MANT_W = 21;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        EXACT    = 2'd0,
        INEXACT  = 2'd1,
        OVERFLOW = 2'd2,
        INVALID  = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word_t;

    function automatic fp_word_t to_fp_word(input logic [WORD_W-1:0] w);
        return fp_word_t'(w);
    endfunction

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one FPU between two requesters; one operation in flight at a time,
// with a bounded wait for the FPU and a timeout response if it never completes.
module fpu_scheduler
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clock_100Khz,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WORD_W-1:0] req0_op_a,
    input  logic [WORD_W-1:0] req0_op_b,
    input  logic [WORD_W-1:0] req1_op_a,
    input  logic [WORD_W-1:0] req1_op_b,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output status_t           rsp_status,
    output logic [WORD_W-1:0] fpu_op_a,
    output logic [WORD_W-1:0] fpu_op_b,
    output logic              fpu_start,
    input  logic              fpu_done,
    input  logic [WORD_W-1:0] fpu_result,
    input  status_t           fpu_status,
    output logic              timeout_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t      state;
    logic              grant_idx;
    logic              last_ptr;
    logic [WORD_W-1:0] op_a_q;
    logic [WORD_W-1:0] op_b_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        arb_gnt;
    logic              accept;
    logic              wait_expired;

    rr_arbiter2 u_arb (
        .req  (req_valid),
        .last (last_ptr),
        .gnt  (arb_gnt)
    );

    // Outputs are gated by reset so req_ready cannot leak a grant while held in reset.
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        fpu_start    = 1'b0;
        timeout_err  = 1'b0;
        fpu_op_a     = '0;
        fpu_op_b     = '0;
        wait_expired = (wait_cnt == CNT_LAST);
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    req_ready = arb_gnt;
                end
                ST_ISSUE: begin
                    fpu_start = 1'b1;
                    fpu_op_a  = op_a_q;
                    fpu_op_b  = op_b_q;
                end
                ST_WAIT: begin
                    fpu_op_a    = op_a_q;
                    fpu_op_b    = op_b_q;
                    timeout_err = wait_expired & ~fpu_done;
                end
                default: begin
                    rsp_valid = idx_to_onehot(grant_idx);
                end
            endcase
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant_idx  <= 1'b0;
            last_ptr   <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            wait_cnt   <= '0;
            rsp_data   <= '0;
            rsp_status <= EXACT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_idx <= arb_gnt[1];
                        last_ptr  <= arb_gnt[1];
                        op_a_q    <= arb_gnt[1] ? req1_op_a : req0_op_a;
                        op_b_q    <= arb_gnt[1] ? req1_op_b : req0_op_b;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the last allowed cycle beats the timeout.
                    if (fpu_done) begin
                        rsp_data   <= fpu_result;
                        rsp_status <= fpu_status;
                        state      <= ST_RESPOND;
                    end else if (wait_expired) begin
                        rsp_data   <= '0;
                        rsp_status <= INEXACT;
                        state      <= ST_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (rsp_ready[grant_idx]) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Bench for fpu_scheduler: directed vector table, reset/backpressure sequences,
// and a randomized run against a transaction-level model with an FPU stub.
module tb_fpu_scheduler;
    import fpu_pkg::*;

    localparam int unsigned TO = 8;

    logic        clock_100Khz = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [31:0] rsp_data, fpu_op_a, fpu_op_b, fpu_result;
    status_t     rsp_status, fpu_status;
    logic        fpu_start, fpu_done, timeout_err;

    int checks   = 0;
    int failures = 0;

    fpu_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_op_a    (req0_op_a),
        .req0_op_b    (req0_op_b),
        .req1_op_a    (req1_op_a),
        .req1_op_b    (req1_op_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_start    (fpu_start),
        .fpu_done     (fpu_done),
        .fpu_result   (fpu_result),
        .fpu_status   (fpu_status),
        .timeout_err  (timeout_err)
    );

    always #5 clock_100Khz = ~clock_100Khz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_event required=event_within_bound", name);
    endtask

    // Behavioural FPU: result is the integer sum, status from operand low bits.
    function automatic logic [33:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
        return {a[1:0] ^ b[1:0], a + b};
    endfunction

    // FPU stub: answers stub_delay cycles after fpu_start (0 = never).
    int          stub_mode   = 0;
    int          stub_delay  = 0;
    int          stub_cnt    = -1;
    int          stub_last_d = 0;
    logic [31:0] stub_res    = '0;
    status_t     stub_st     = EXACT;
    logic [31:0] stub_a, stub_b;

    initial begin
        logic [33:0] m;
        fpu_done   = 1'b0;
        fpu_result = '0;
        fpu_status = EXACT;
        forever begin
            @(posedge clock_100Khz);
            #1;
            fpu_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    fpu_done = 1'b1;
                    if (stub_mode == 1) begin
                        m          = fpu_model(stub_a, stub_b);
                        fpu_result = m[31:0];
                        fpu_status = status_t'(m[33:32]);
                    end else begin
                        fpu_result = stub_res;
                        fpu_status = stub_st;
                    end
                    stub_cnt = -1;
                end
            end
            if (fpu_start) begin
                stub_a      = fpu_op_a;
                stub_b      = fpu_op_b;
                stub_last_d = (stub_mode == 1) ? int'($urandom_range(1, 10)) : stub_delay;
                stub_cnt    = (stub_last_d > 0) ? stub_last_d : -1;
            end
        end
    end

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0, a1, b1;
        int          delay;
        logic [31:0] res;
        status_t     st;
        logic [1:0]  grant;
        logic [31:0] data;
        status_t     dst;
        logic        to;
        int          lat;
    } vec_t;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {req_ready, rsp_valid, fpu_start, timeout_err}, '0);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_status"}, rsp_status, EXACT);
        check({tag, "_fpu_ops"}, {fpu_op_a, fpu_op_b}, '0);
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clock_100Khz);
            if (|(req_valid & req_ready)) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clock_100Khz);
            if (rsp_valid != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          k, start_k, to_k, starts, tos, waited;
        bit          got;
        logic [31:0] ea, eb;
        ea = v.grant[1] ? v.a1 : v.a0;
        eb = v.grant[1] ? v.b1 : v.b0;
        @(posedge clock_100Khz);
        #1;
        stub_mode  = 0;
        stub_delay = v.delay;
        stub_res   = v.res;
        stub_st    = v.st;
        req_valid  = v.valid;
        req0_op_a  = v.a0;
        req0_op_b  = v.b0;
        req1_op_a  = v.a1;
        req1_op_b  = v.b1;
        rsp_ready  = 2'b00;
        got    = 1'b0;
        waited = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clock_100Khz);
            if (|(req_valid & req_ready)) begin
                got    = 1'b1;
                waited = w;
            end
        end
        if (!got) begin
            fail_now($sformatf("vec%0d_accept", idx));
            req_valid = 2'b00;
            return;
        end
        check($sformatf("vec%0d_grant", idx), req_ready, v.grant);
        check($sformatf("vec%0d_accept_wait", idx), waited, 0);
        @(posedge clock_100Khz);
        #1;
        req_valid = 2'b00;
        k = 0; starts = 0; tos = 0; start_k = -1; to_k = -1; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clock_100Khz);
            k++;
            if (fpu_start) begin
                starts++;
                start_k = k;
                check($sformatf("vec%0d_fpu_ops", idx), {fpu_op_a, fpu_op_b}, {ea, eb});
            end
            if (timeout_err) begin
                tos++;
                to_k = k;
            end
            if (rsp_valid != 2'b00) got = 1'b1;
        end
        if (!got) begin
            fail_now($sformatf("vec%0d_response", idx));
            return;
        end
        check($sformatf("vec%0d_rsp_valid", idx), rsp_valid, v.grant);
        check($sformatf("vec%0d_latency", idx), k, v.lat);
        check($sformatf("vec%0d_payload", idx), {rsp_status, rsp_data}, {v.dst, v.data});
        check($sformatf("vec%0d_start_once", idx), {starts[7:0], start_k[7:0]}, {8'd1, 8'd1});
        check($sformatf("vec%0d_timeout_cnt", idx), tos, v.to);
        if (v.to) check($sformatf("vec%0d_timeout_cycle", idx), to_k, v.lat - 1);
        // Ready from the other requester must not complete the response.
        @(posedge clock_100Khz);
        #1;
        rsp_ready = ~v.grant;
        @(negedge clock_100Khz);
        check($sformatf("vec%0d_wrong_ready_ignored", idx), rsp_valid, v.grant);
        @(posedge clock_100Khz);
        #1;
        rsp_ready = v.grant;
        @(negedge clock_100Khz);
        check($sformatf("vec%0d_payload_held", idx), {rsp_valid, rsp_status, rsp_data}, {v.grant, v.dst, v.data});
        @(posedge clock_100Khz);
        #1;
        rsp_ready = 2'b00;
        @(negedge clock_100Khz);
        check($sformatf("vec%0d_released", idx), rsp_valid, 2'b00);
    endtask

    initial begin
        vec_t        vecs[9];
        vec_t        vpost;
        bit          ok;
        bit          busy;
        logic        m_g, model_last;
        logic [31:0] m_a, m_b;
        logic [1:0]  pred, acc_prev;
        logic [33:0] exp_pl;
        int          starts, tos, age, n_ops;

        vecs[0] = '{2'b01, 32'h4020_0000, 32'h4010_0000, 32'h0, 32'h0, 3, 32'h4030_0000, EXACT,
                    2'b01, 32'h4030_0000, EXACT, 1'b0, 5};
        vecs[1] = '{2'b11, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1, 32'h3F80_0000, OVERFLOW,
                    2'b10, 32'h3F80_0000, OVERFLOW, 1'b0, 3};
        vecs[2] = '{2'b11, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 2, 32'h0000_1234, INVALID,
                    2'b01, 32'h0000_1234, INVALID, 1'b0, 4};
        vecs[3] = '{2'b11, 32'h9999_0000, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 4, 32'h4100_0000, INEXACT,
                    2'b10, 32'h4100_0000, INEXACT, 1'b0, 6};
        vecs[4] = '{2'b11, 32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4, 1, 32'hC000_0001, EXACT,
                    2'b01, 32'hC000_0001, EXACT, 1'b0, 3};
        vecs[5] = '{2'b10, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, EXACT,
                    2'b10, 32'h0, INEXACT, 1'b1, 10};
        vecs[6] = '{2'b10, 32'h0, 32'h0, 32'h1234_5678, 32'h8765_4321, 8, 32'h1357_9BDF, EXACT,
                    2'b10, 32'h1357_9BDF, EXACT, 1'b0, 10};
        vecs[7] = '{2'b01, 32'hABCD_0001, 32'hABCD_0002, 32'h0, 32'h0, 9, 32'h2468_ACE0, EXACT,
                    2'b01, 32'h0, INEXACT, 1'b1, 10};
        vecs[8] = '{2'b11, 32'h0000_0F01, 32'h0000_0F02, 32'h0000_0F03, 32'h0000_0F04, 1, 32'h0F0F_0F0F, OVERFLOW,
                    2'b10, 32'h0F0F_0F0F, OVERFLOW, 1'b0, 3};
        vpost   = '{2'b11, 32'h0102_0304, 32'h0506_0708, 32'hF0F0_0000, 32'h0F0F_0000, 1, 32'h7777_0000, EXACT,
                    2'b01, 32'h7777_0000, EXACT, 1'b0, 3};

        reset     = 1'b0;
        req_valid = 2'b11;
        req0_op_a = 32'h1; req0_op_b = 32'h2; req1_op_a = 32'h3; req1_op_b = 32'h4;
        rsp_ready = 2'b00;
        #12;
        check_reset_outputs("in_reset");
        @(negedge clock_100Khz);
        req_valid = 2'b00;
        reset     = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Response held under backpressure while both requesters keep asking.
        @(posedge clock_100Khz);
        #1;
        stub_mode = 0; stub_delay = 2; stub_res = 32'h4248_0000; stub_st = INEXACT;
        req_valid = 2'b01; req0_op_a = 32'h4000_0000; req0_op_b = 32'h4008_0000;
        wait_accept(ok);
        if (!ok) fail_now("hold_accept");
        @(posedge clock_100Khz);
        #1;
        req_valid = 2'b11;
        wait_rsp(ok);
        if (!ok) fail_now("hold_response");
        repeat (10) begin
            @(posedge clock_100Khz);
            #1;
            rsp_ready = 2'b10;
            @(negedge clock_100Khz);
            check("hold_stable", {rsp_valid, req_ready, rsp_status, rsp_data},
                  {2'b01, 2'b00, INEXACT, 32'h4248_0000});
        end
        @(posedge clock_100Khz);
        #1;
        rsp_ready = 2'b01;
        req_valid = 2'b00;
        @(negedge clock_100Khz);
        @(posedge clock_100Khz);
        #1;
        rsp_ready = 2'b00;
        @(negedge clock_100Khz);
        check("hold_release", rsp_valid, 2'b00);

        // Reset while waiting on the FPU; its late completion must be dropped.
        @(posedge clock_100Khz);
        #1;
        stub_mode = 0; stub_delay = 5; stub_res = 32'hCAFE_F00D; stub_st = OVERFLOW;
        req_valid = 2'b10; req1_op_a = 32'h5151_5151; req1_op_b = 32'h6262_6262;
        wait_accept(ok);
        if (!ok) fail_now("rst_accept");
        @(posedge clock_100Khz);
        #1;
        req_valid = 2'b00;
        ok = 1'b0;
        for (int w = 0; w < 10 && !ok; w++) begin
            @(negedge clock_100Khz);
            if (fpu_start) ok = 1'b1;
        end
        if (!ok) fail_now("rst_start");
        @(posedge clock_100Khz);
        #1;
        req_valid = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_wait_reset");
        @(negedge clock_100Khz);
        req_valid = 2'b00;
        reset     = 1'b1;
        repeat (6) begin
            @(negedge clock_100Khz);
            check("post_reset_quiet", {rsp_valid, fpu_start, timeout_err, rsp_data}, '0);
        end
        run_vec(99, vpost);

        // Randomized traffic against the transaction model.
        @(negedge clock_100Khz);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        reset     = 1'b0;
        #2;
        reset     = 1'b1;
        stub_mode  = 1;
        model_last = 1'b1;
        busy       = 1'b0;
        acc_prev   = 2'b00;
        starts = 0; tos = 0; age = 0; n_ops = 0;
        m_g = 1'b0; m_a = '0; m_b = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(posedge clock_100Khz);
            #1;
            if (!req_valid[0] || acc_prev[0]) begin
                req_valid[0] = (cyc < 620) && ($urandom_range(0, 2) == 0);
                req0_op_a    = $urandom;
                req0_op_b    = $urandom;
            end
            if (!req_valid[1] || acc_prev[1]) begin
                req_valid[1] = (cyc < 620) && ($urandom_range(0, 2) == 0);
                req1_op_a    = $urandom;
                req1_op_b    = $urandom;
            end
            rsp_ready = (cyc < 620) ? 2'($urandom_range(0, 3)) : 2'b11;
            @(negedge clock_100Khz);
            acc_prev = 2'b00;
            if (!busy) begin
                pred = (req_valid == 2'b11) ? (model_last ? 2'b01 : 2'b10) : req_valid;
                check("rand_idle_ready", req_ready, pred);
                check("rand_idle_quiet", {rsp_valid, fpu_start, timeout_err, fpu_op_a | fpu_op_b}, '0);
                if (pred != 2'b00) begin
                    busy       = 1'b1;
                    m_g        = pred[1];
                    m_a        = pred[1] ? req1_op_a : req0_op_a;
                    m_b        = pred[1] ? req1_op_b : req0_op_b;
                    model_last = pred[1];
                    acc_prev   = pred;
                    starts = 0; tos = 0; age = 0;
                end
            end else begin
                age++;
                check("rand_busy_not_ready", req_ready, 2'b00);
                if (fpu_start) begin
                    starts++;
                    check("rand_fpu_ops", {fpu_op_a, fpu_op_b}, {m_a, m_b});
                end
                if (timeout_err) tos++;
                if (rsp_valid != 2'b00) begin
                    exp_pl = (stub_last_d <= int'(TO)) ? fpu_model(m_a, m_b) : {2'b01, 32'h0};
                    check("rand_rsp_target", rsp_valid, m_g ? 2'b10 : 2'b01);
                    check("rand_rsp_payload", {rsp_status, rsp_data}, exp_pl);
                    if (rsp_ready[m_g]) begin
                        check("rand_start_count", starts, 1);
                        check("rand_timeout_count", tos, (stub_last_d > int'(TO)) ? 1 : 0);
                        busy = 1'b0;
                        n_ops++;
                    end
                end else if (age > 80) begin
                    fail_now("rand_response_bound");
                    busy = 1'b0;
                end
            end
        end
        check("rand_drained", busy, 1'b0);
        check("rand_ops_seen", n_ops > 20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_scheduler.md
FPU_SCHEDULER -- requirements
Module: fpu_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max WAIT cycles before abort.
REQ-002 SHALL have port clock_100Khz  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid / req_ready  in / out  2 / 2  per-requester valid/ready, bit i = requester i.
REQ-005 SHALL have ports req0_op_a, req0_op_b, req1_op_a, req1_op_b  in  32  operands (1 sign, 10 exp, 21 mantissa).
REQ-006 SHALL have ports rsp_valid / rsp_ready  out / in  2 / 2  per-requester response handshake.
REQ-007 SHALL have ports rsp_data  out  32  result, and rsp_status  out  status_t  result status.
REQ-008 SHALL have ports fpu_op_a, fpu_op_b  out  32  operands driven to the shared FPU datapath.
REQ-009 SHALL have port fpu_start  out  1  one-cycle pulse that launches the FPU.
REQ-010 SHALL have ports fpu_done  in  1, fpu_result  in  32, fpu_status  in  status_t  FPU completion strobe and payload.
REQ-011 SHALL have port timeout_err  out  1  one-cycle pulse on abort.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE; only one operation SHALL be in flight.
REQ-013 IDLE: req_ready SHALL be asserted combinationally, and only for the granted requester; all other req_ready bits SHALL be 0.
REQ-014 Grant SHALL be round-robin: if both requesters are valid, the one not granted last wins; if only one is valid, it wins.
REQ-015 On req_valid[g] & req_ready[g], the block SHALL latch the operands and g, update the last-grant pointer, and go to ISSUE.
REQ-016 ISSUE SHALL last exactly 1 cycle with fpu_start=1, then go to WAIT with the wait counter cleared.
REQ-017 fpu_op_a/fpu_op_b SHALL hold the latched operands from ISSUE through WAIT; otherwise they SHALL be 0.
REQ-018 WAIT: on fpu_done=1 the block SHALL capture fpu_result/fpu_status into rsp_data/rsp_status and go to RESPOND.
REQ-019 WAIT: if counter reaches TIMEOUT_CYCLES-1 without fpu_done, the block SHALL set rsp_data=0 and rsp_status=INEXACT, pulse timeout_err, and go to RESPOND.
REQ-020 If fpu_done and timeout occur in the same cycle, fpu_done SHALL win and timeout_err SHALL stay 0.
REQ-021 fpu_done outside WAIT SHALL be ignored.
REQ-022 RESPOND: rsp_valid[g] SHALL be held at 1, with rsp_data/rsp_status stable, until rsp_ready[g]; then the block SHALL go to IDLE.
REQ-023 rsp_ready of the non-granted requester SHALL be ignored.
REQ-024 Minimum latency SHALL be: accept at cycle N, fpu_start at N+1, fpu_done sampled at N+2, rsp_valid at N+3.
REQ-025 After a response handshake, a new accept SHALL be possible in the following IDLE cycle.
REQ-026 The wait counter SHALL be sized ceil(log2(TIMEOUT_CYCLES))+1 bits and SHALL NOT wrap.

Reset
REQ-027 Asserting reset SHALL force IDLE immediately, including mid-operation.
REQ-028 During reset, req_ready, rsp_valid, fpu_start and timeout_err SHALL be 0, and rsp_data, fpu_op_a and fpu_op_b SHALL be 32'h0.
REQ-029 Reset values SHALL be rsp_status=EXACT and last-grant pointer=1, so requester 0 wins first.
REQ-030 An in-flight operation SHALL be discarded on reset, with no response issued.

Structure
REQ-031 status_t, the scheduler state enum, and constants EXP_W=10, MANT_W=21, WORD_W=32 SHALL live in shared package fpu_pkg, also used by the FPU datapath.
REQ-032 Grant logic SHALL be sub-module rr_arbiter2 (2-bit request, 1-bit last pointer -> one-hot grant).

Verification
REQ-033 Scenario: req0 only, A=32'h4020_0000, B=32'h4010_0000; stub returns fpu_done 3 cycles after start with result 32'h4030_0000, EXACT -> rsp_valid[0] with those values, fpu_start exactly 1 cycle.
REQ-034 Scenario: req0 and req1 both valid continuously for 4 ops -> grants in order 0,1,0,1; rsp_valid toward the wrong requester is never seen.
REQ-035 Scenario: stub never asserts fpu_done, TIMEOUT_CYCLES=8 -> timeout_err pulse after 8 WAIT cycles, rsp_data=0, rsp_status=INEXACT.
REQ-036 Scenario: rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable for all 10 cycles; req_ready stays 0 throughout.
REQ-037 Scenario: reset asserted during WAIT -> same-cycle IDLE with all outputs at reset values; a late fpu_done is ignored; the next request is granted to requester 0.
REQ-038 Scenario: fpu_done on the final timeout cycle -> result delivered, timeout_err=0.
